// File: rtl/lcd_rx_monitor.sv
// Receive-side checker for the parallel RGB565 LCD bus: recovers pixel coordinates,
// measures frame geometry against the expected panel size and reports lock, errors and a checksum.
module lcd_rx_monitor #(
    parameter int H_ACTIVE        = 480,
    parameter int V_ACTIVE        = 272,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        PIXEL_CLK,
    input  logic        RESETn,
    input  logic        HSYNC,
    input  logic        VSYNC,
    input  logic        DEN,
    input  logic [4:0]  R,
    input  logic [5:0]  G,
    input  logic [4:0]  B,
    output logic        RX_VALID,
    output logic [10:0] RX_X,
    output logic [10:0] RX_Y,
    output logic [15:0] RX_PIX,
    output logic        FRAME_DONE,
    output logic [10:0] MEAS_WIDTH,
    output logic [10:0] MEAS_HEIGHT,
    output logic [15:0] FRAME_SUM,
    output logic        ERR_WIDTH,
    output logic        ERR_HEIGHT,
    output logic        ERR_SYNC,
    output logic        LOCKED
);
    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam logic [10:0] H_EXP   = 11'(H_ACTIVE);
    localparam logic [10:0] V_EXP   = 11'(V_ACTIVE);

    typedef enum logic [1:0] {S_UNLOCKED, S_ACQUIRE, S_LOCKED} state_t;

    state_t      state;
    logic        hs_r, vs_r, den_r, vs_d, den_d;
    logic [15:0] pix_r;
    logic [10:0] x_cnt, y_cnt, last_width;
    logic [15:0] sum_acc;
    logic        err_w_l, err_s_l;

    logic        vs_rise, den_fall;
    logic [10:0] y_nxt, lw_nxt;
    logic [15:0] sum_nxt;
    logic        ew_nxt, es_nxt, frame_err;

    assign vs_rise  = vs_r & ~vs_d;
    assign den_fall = den_d & ~den_r;

    // Next-state views of the frame accumulators so a line ending on the same
    // edge as the frame sync is folded into the frame being closed.
    always_comb begin
        y_nxt     = (den_fall && y_cnt != CNT_MAX) ? y_cnt + 11'd1 : y_cnt;
        // x_cnt already includes the final pixel of the line when den_fall is seen
        lw_nxt    = den_fall ? x_cnt : last_width;
        ew_nxt    = err_w_l | (den_fall && x_cnt != H_EXP);
        es_nxt    = err_s_l | (den_r & (hs_r | vs_r));
        sum_nxt   = den_r ? sum_acc + pix_r : sum_acc;
        frame_err = ew_nxt | es_nxt | (y_nxt != V_EXP);
    end

    always_ff @(posedge PIXEL_CLK or negedge RESETn) begin
        if (!RESETn) begin
            hs_r     <= 1'b0;
            vs_r     <= 1'b0;
            den_r    <= 1'b0;
            pix_r    <= '0;
            vs_d     <= 1'b0;
            den_d    <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            RX_VALID <= 1'b0;
            RX_X     <= '0;
            RX_Y     <= '0;
            RX_PIX   <= '0;
        end else begin
            hs_r     <= HSYNC ^ SYNC_ACTIVE_LOW;
            vs_r     <= VSYNC ^ SYNC_ACTIVE_LOW;
            den_r    <= DEN;
            pix_r    <= {R, G, B};
            vs_d     <= vs_r;
            den_d    <= den_r;
            RX_VALID <= den_r;
            RX_X     <= x_cnt;
            RX_Y     <= y_cnt;
            RX_PIX   <= pix_r;
            if (den_fall)
                x_cnt <= '0;
            else if (den_r && x_cnt != CNT_MAX)
                x_cnt <= x_cnt + 11'd1;
            y_cnt <= vs_rise ? 11'd0 : y_nxt;
        end
    end

    always_ff @(posedge PIXEL_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state       <= S_UNLOCKED;
            last_width  <= '0;
            sum_acc     <= '0;
            err_w_l     <= 1'b0;
            err_s_l     <= 1'b0;
            FRAME_DONE  <= 1'b0;
            MEAS_WIDTH  <= '0;
            MEAS_HEIGHT <= '0;
            FRAME_SUM   <= '0;
            ERR_WIDTH   <= 1'b0;
            ERR_HEIGHT  <= 1'b0;
            ERR_SYNC    <= 1'b0;
            LOCKED      <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                S_UNLOCKED: begin
                    if (vs_rise)
                        state <= S_ACQUIRE;
                end
                default: begin
                    if (vs_rise) begin
                        MEAS_WIDTH  <= lw_nxt;
                        MEAS_HEIGHT <= y_nxt;
                        FRAME_SUM   <= sum_nxt;
                        ERR_WIDTH   <= ew_nxt;
                        ERR_HEIGHT  <= (y_nxt != V_EXP);
                        ERR_SYNC    <= es_nxt;
                        FRAME_DONE  <= 1'b1;
                        state       <= frame_err ? S_ACQUIRE : S_LOCKED;
                        LOCKED      <= ~frame_err;
                        last_width  <= '0;
                        sum_acc     <= '0;
                        err_w_l     <= 1'b0;
                        err_s_l     <= 1'b0;
                    end else begin
                        last_width <= lw_nxt;
                        sum_acc    <= sum_nxt;
                        err_w_l    <= ew_nxt;
                        err_s_l    <= es_nxt;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Directed bench for lcd_rx_monitor: table of frames, each closed by a VSYNC edge,
// plus hand-written reset and pipeline-latency sequences.
module tb_lcd_rx_monitor;
    logic        PIXEL_CLK = 1'b0;
    logic        RESETn;
    logic        HSYNC, VSYNC, DEN;
    logic [4:0]  R;
    logic [5:0]  G;
    logic [4:0]  B;
    logic        RX_VALID, FRAME_DONE, ERR_WIDTH, ERR_HEIGHT, ERR_SYNC, LOCKED;
    logic [10:0] RX_X, RX_Y, MEAS_WIDTH, MEAS_HEIGHT;
    logic [15:0] RX_PIX, FRAME_SUM;

    int checks = 0;
    int errors = 0;

    lcd_rx_monitor #(.H_ACTIVE(8), .V_ACTIVE(4), .SYNC_ACTIVE_LOW(1'b1)) dut (
        .PIXEL_CLK(PIXEL_CLK), .RESETn(RESETn), .HSYNC(HSYNC), .VSYNC(VSYNC), .DEN(DEN),
        .R(R), .G(G), .B(B), .RX_VALID(RX_VALID), .RX_X(RX_X), .RX_Y(RX_Y), .RX_PIX(RX_PIX),
        .FRAME_DONE(FRAME_DONE), .MEAS_WIDTH(MEAS_WIDTH), .MEAS_HEIGHT(MEAS_HEIGHT),
        .FRAME_SUM(FRAME_SUM), .ERR_WIDTH(ERR_WIDTH), .ERR_HEIGHT(ERR_HEIGHT),
        .ERR_SYNC(ERR_SYNC), .LOCKED(LOCKED)
    );

    always #5 PIXEL_CLK = ~PIXEL_CLK;

    typedef struct {
        int lines;
        int short_line;
        bit sync_bad;
        bit exp_done;
        int exp_w;
        int exp_h;
        bit ew;
        bit eh;
        bit es;
        bit lk;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge PIXEL_CLK);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_valid"}, RX_VALID, 0);
        chk({tag, "_rx_x"}, RX_X, 0);
        chk({tag, "_rx_y"}, RX_Y, 0);
        chk({tag, "_rx_pix"}, RX_PIX, 0);
        chk({tag, "_frame_done"}, FRAME_DONE, 0);
        chk({tag, "_meas_w"}, MEAS_WIDTH, 0);
        chk({tag, "_meas_h"}, MEAS_HEIGHT, 0);
        chk({tag, "_sum"}, FRAME_SUM, 0);
        chk({tag, "_errs"}, {ERR_WIDTH, ERR_HEIGHT, ERR_SYNC}, 0);
        chk({tag, "_locked"}, LOCKED, 0);
    endtask

    // Drives one frame of lines; pixel value = x + 16*y. Returns the expected checksum.
    task automatic send_frame(input int lines, input int short_line, input bit sync_bad,
                              output int fsum);
        int w;
        int val;
        fsum = 0;
        for (int l = 0; l < lines; l++) begin
            HSYNC = 1'b0;
            idle(2);
            HSYNC = 1'b1;
            idle(2);
            w = (l == short_line) ? 7 : 8;
            for (int p = 0; p < w; p++) begin
                if (l == 1 && p == 1)
                    chk("rx_lat_early_valid", RX_VALID, 0);
                if (l == 1 && p == 2) begin
                    chk("rx_lat_valid", RX_VALID, 1);
                    chk("rx_lat_x", RX_X, 0);
                    chk("rx_lat_y", RX_Y, 1);
                    chk("rx_lat_pix", RX_PIX, 16'h0010);
                end
                val = p + 16 * l;
                {R, G, B} = 16'(val);
                DEN = 1'b1;
                HSYNC = (sync_bad && l == 0 && p == 0) ? 1'b0 : 1'b1;
                fsum += val;
                @(negedge PIXEL_CLK);
            end
            DEN = 1'b0;
            HSYNC = 1'b1;
            idle(3);
        end
        fsum = fsum & 16'hFFFF;
    endtask

    // Asserts VSYNC and counts FRAME_DONE pulses within a bounded window.
    task automatic vsync_edge(output int n_done);
        n_done = 0;
        VSYNC = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PIXEL_CLK);
            if (FRAME_DONE) n_done++;
        end
        VSYNC = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge PIXEL_CLK);
            if (FRAME_DONE) n_done++;
        end
    endtask

    initial begin
        int nd;
        int fsum;
        int exp_sum;

        //         lines short bad  done w  h  ew eh es lk
        vecs[0]  = '{0, -1, 0,   0,  0, 0, 0, 0, 0, 0};
        vecs[1]  = '{4, -1, 0,   1,  8, 4, 0, 0, 0, 1};
        vecs[2]  = '{4, -1, 0,   1,  8, 4, 0, 0, 0, 1};
        vecs[3]  = '{4,  2, 0,   1,  8, 4, 1, 0, 0, 0};
        vecs[4]  = '{4, -1, 0,   1,  8, 4, 0, 0, 0, 1};
        vecs[5]  = '{5, -1, 0,   1,  8, 5, 0, 1, 0, 0};
        vecs[6]  = '{4, -1, 0,   1,  8, 4, 0, 0, 0, 1};
        vecs[7]  = '{4, -1, 1,   1,  8, 4, 0, 0, 1, 0};
        vecs[8]  = '{4, -1, 0,   1,  8, 4, 0, 0, 0, 1};
        vecs[9]  = '{0, -1, 0,   1,  0, 0, 0, 1, 0, 0};
        vecs[10] = '{4, -1, 0,   1,  8, 4, 0, 0, 0, 1};

        RESETn = 1'b0;
        HSYNC = 1'b1;
        VSYNC = 1'b1;
        DEN = 1'b0;
        {R, G, B} = 16'h0;
        idle(3);
        #1 chk_all_zero("reset");
        @(negedge PIXEL_CLK);
        RESETn = 1'b1;
        idle(3);

        exp_sum = 0;
        for (int i = 0; i < 11; i++) begin
            send_frame(vecs[i].lines, vecs[i].short_line, vecs[i].sync_bad, fsum);
            vsync_edge(nd);
            if (vecs[i].exp_done) exp_sum = fsum;
            chk($sformatf("v%0d_done", i), nd, vecs[i].exp_done ? 1 : 0);
            chk($sformatf("v%0d_meas_w", i), MEAS_WIDTH, vecs[i].exp_w);
            chk($sformatf("v%0d_meas_h", i), MEAS_HEIGHT, vecs[i].exp_h);
            chk($sformatf("v%0d_sum", i), FRAME_SUM, exp_sum);
            chk($sformatf("v%0d_err_w", i), ERR_WIDTH, vecs[i].ew);
            chk($sformatf("v%0d_err_h", i), ERR_HEIGHT, vecs[i].eh);
            chk($sformatf("v%0d_err_s", i), ERR_SYNC, vecs[i].es);
            chk($sformatf("v%0d_locked", i), LOCKED, vecs[i].lk);
            idle(2);
        end

        // Mid-line reset of a locked stream
        HSYNC = 1'b0;
        idle(2);
        HSYNC = 1'b1;
        idle(2);
        for (int p = 0; p < 4; p++) begin
            {R, G, B} = 16'(p + 1);
            DEN = 1'b1;
            @(negedge PIXEL_CLK);
        end
        RESETn = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge PIXEL_CLK);
        DEN = 1'b0;
        idle(2);
        RESETn = 1'b1;
        idle(3);

        vsync_edge(nd);
        chk("post_reset_first_edge_done", nd, 0);
        chk("post_reset_first_edge_locked", LOCKED, 0);
        idle(2);
        send_frame(4, -1, 0, fsum);
        vsync_edge(nd);
        chk("post_reset_done", nd, 1);
        chk("post_reset_meas_w", MEAS_WIDTH, 8);
        chk("post_reset_meas_h", MEAS_HEIGHT, 4);
        chk("post_reset_sum", FRAME_SUM, fsum);
        chk("post_reset_errs", {ERR_WIDTH, ERR_HEIGHT, ERR_SYNC}, 0);
        chk("post_reset_locked", LOCKED, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
